// File: rtl/datapath_rf.sv
// datapath_rf: register file plus ALU, one command per valid/ready handshake.
// Define DATAPATH_RF_MUL_EN to make opcode 111 an iterative WIDTH-cycle multiply.
module datapath_rf #(
    parameter int WIDTH = 8,
    parameter int NREGS = 4,
    localparam int ADDR_W = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [ADDR_W-1:0] cmd_src,
    input  logic [WIDTH-1:0]  cmd_imm,
    input  logic              cmd_use_imm,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data,
    output logic              res_valid,
    output logic [WIDTH-1:0]  res_data,
    output logic              carry_out,
    output logic              zero_out,
    output logic              busy
);

    localparam logic [2:0] OP_LOAD = 3'b000;
    localparam logic [2:0] OP_AND  = 3'b001;
    localparam logic [2:0] OP_OR   = 3'b010;
    localparam logic [2:0] OP_XOR  = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;
    localparam logic [2:0] OP_SHL  = 3'b110;
    localparam logic [2:0] OP_MUL  = 3'b111;

    logic [WIDTH-1:0] regs [NREGS];
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_wr;
    logic             accept;

    assign op_a    = regs[cmd_dst];
    assign op_b    = cmd_use_imm ? cmd_imm : regs[cmd_src];
    assign sum     = {1'b0, op_a} + {1'b0, op_b};
    assign diff    = {1'b0, op_a} - {1'b0, op_b};
    assign rd_data = regs[rd_addr];
    assign accept  = cmd_valid & cmd_ready;

    always_comb begin
        alu_res = op_a;
        alu_c   = 1'b0;
        alu_wr  = 1'b1;
        unique case (cmd_op)
            OP_LOAD: alu_res = op_b;
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
            end
            OP_SUB: begin
                alu_res = diff[WIDTH-1:0];
                alu_c   = diff[WIDTH];
            end
            OP_SHL: begin
                alu_res = {op_a[WIDTH-2:0], 1'b0};
                alu_c   = op_a[WIDTH-1];
            end
            OP_MUL: alu_wr = 1'b0;
        endcase
    end

`ifdef DATAPATH_RF_MUL_EN
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic                ready_raw;
    logic                mul_start;
    logic                mul_done;
    logic [CNT_W-1:0]    cnt_q;
    logic [2*WIDTH-1:0]  acc_q;
    logic [2*WIDTH-1:0]  mcand_q;
    logic [WIDTH-1:0]    mplr_q;
    logic [ADDR_W-1:0]   mdst_q;
    logic [2*WIDTH-1:0]  acc_nxt;
    logic [WIDTH-1:0]    mul_lo;
    logic [WIDTH-1:0]    mul_hi;

    assign mul_start = accept & (cmd_op == OP_MUL);
    assign mul_done  = (state_q == S_MUL) &&
                       (cnt_q == CNT_W'(WIDTH - 1));
    assign acc_nxt   = acc_q + (mplr_q[0] ? mcand_q : '0);
    assign mul_lo    = acc_nxt[WIDTH-1:0];
    assign mul_hi    = acc_nxt[2*WIDTH-1:WIDTH];
    assign cmd_ready = rst_n & ready_raw;

    always_comb begin
        state_d   = state_q;
        ready_raw = 1'b1;
        busy      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (mul_start)
                    state_d = S_MUL;
            end
            S_MUL: begin
                ready_raw = 1'b0;
                busy      = 1'b1;
                if (mul_done)
                    state_d = S_IDLE;
            end
        endcase
    end

    // One shift-add step per cycle; the last step's sum is written directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            mcand_q <= '0;
            mplr_q  <= '0;
            mdst_q  <= '0;
        end else begin
            state_q <= state_d;
            if (mul_start) begin
                cnt_q   <= '0;
                acc_q   <= '0;
                mcand_q <= {{WIDTH{1'b0}}, op_a};
                mplr_q  <= op_b;
                mdst_q  <= cmd_dst;
            end else if (state_q == S_MUL) begin
                cnt_q   <= cnt_q + CNT_W'(1);
                acc_q   <= acc_nxt;
                mcand_q <= mcand_q << 1;
                mplr_q  <= mplr_q >> 1;
            end
        end
    end
`else
    assign cmd_ready = rst_n;
    assign busy      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
            carry_out <= 1'b0;
            zero_out  <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
        end else begin
            res_valid <= 1'b0;
            if (accept && alu_wr) begin
                regs[cmd_dst] <= alu_res;
                carry_out     <= alu_c;
                zero_out      <= (alu_res == '0);
                res_valid     <= 1'b1;
                res_data      <= alu_res;
`ifdef DATAPATH_RF_MUL_EN
            end else if (mul_done) begin
                regs[mdst_q] <= mul_lo;
                carry_out    <= |mul_hi;
                zero_out     <= (mul_lo == '0);
                res_valid    <= 1'b1;
                res_data     <= mul_lo;
`else
            end else if (accept) begin
                // Opcode 111 is a NOP: report dst, keep flags.
                res_valid <= 1'b1;
                res_data  <= op_a;
`endif
            end
        end
    end

endmodule

// File: doc/datapath_rf.md
# datapath_rf

Parametrised successor to the 4-bit accumulator datapath. It holds a small register file and an ALU, and executes one command per valid/ready handshake. The ALU combines a destination register with either a source register or an immediate, and writes the result back to the destination. Result and flags are reported one cycle after the write. The block sits between the command sequencer and the result bus.

## Interface
- WIDTH, 8, data width in bits (≥2)
- NREGS, 4, register count (power of two, ≥2); ADDR_W = $clog2(NREGS) is a derived localparam
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_op  in  3  opcode (see Operation)
- cmd_dst  in  ADDR_W  destination register; also operand A
- cmd_src  in  ADDR_W  source register for operand B
- cmd_imm  in  WIDTH  immediate for operand B
- cmd_use_imm  in  1  1: B = cmd_imm; 0: B = reg[cmd_src]
- rd_addr  in  ADDR_W  debug read address
- rd_data  out  WIDTH  reg[rd_addr], combinational read
- res_valid  out  1  one-cycle pulse with result
- res_data  out  WIDTH  value written (or dst value for NOP)
- carry_out  out  1  carry/borrow/overflow flag
- zero_out  out  1  result == 0 flag
- busy  out  1  multi-cycle operation in progress

## Operation
- Accept: cmd_valid & cmd_ready at a rising edge. Operands are sampled at that edge.
- Opcodes (A = reg[dst], B per cmd_use_imm):
  - 000 LOAD: dst ← B
  - 001 AND; 010 OR; 011 XOR
  - 100 ADD
  - 101 SUB: A − B
  - 110 SHL: dst ← A << 1, and carry takes the shifted-out MSB
  - 111 MUL (see Configuration)
- All arithmetic is modulo 2^WIDTH.
- carry_out per opcode:
  - ADD: carry out of the MSB
  - SUB: borrow, i.e. 1 iff A < B unsigned
  - LOAD and logic ops: cleared to 0
- zero_out = (written result == 0). Flags update on the same edge as the register write.
- Register dst == src is legal; operands are read before the write.
- FSM states:
  - IDLE: cmd_ready = 1
  - MUL: exists only with the macro; cmd_ready = 0, busy = 1
- Transitions: IDLE → MUL on an accepted 111. MUL → IDLE after WIDTH iterations.
- Commands arriving while cmd_ready = 0 are ignored. cmd_valid may stay high; the command is accepted on the first edge where cmd_ready = 1.

## Timing
- Reset values (async, while rst_n = 0):
  - all registers 0
  - carry_out 0, zero_out 0
  - res_valid 0, res_data 0
  - busy 0
  - state IDLE
  - cmd_ready 0 while rst_n is low, 1 once released
- Single-cycle ops: register write and flags at acceptance edge E.
  - res_valid = 1 for the cycle after E, with res_data = written value.
  - Back-to-back accepts are legal every cycle. A dependent command sees the new value.
- rd_data reflects a write from the cycle after the write edge.
- MUL accepted at edge E:
  - busy = 1 and cmd_ready = 0 from after E through edge E+WIDTH.
  - Write and flags happen at E+WIDTH.
  - res_valid is high in the cycle after E+WIDTH.
  - The next command can be accepted at E+WIDTH+1.
- Reset asserted mid-MUL: abort immediately. No write occurs and no res_valid is produced.

## Configuration
- DATAPATH_RF_MUL_EN defined: opcode 111 is an iterative shift-add unsigned multiply taking WIDTH cycles.
  - dst ← low WIDTH bits of A·B.
  - carry_out = 1 iff the high WIDTH bits are nonzero.
  - zero_out reflects the low half.
- Not defined: no MUL state and busy is tied to 0. Opcode 111 is a single-cycle NOP:
  - no register write, flags unchanged
  - res_valid still pulses, with res_data = reg[dst]

## Test plan
All scenarios use WIDTH=4, NREGS=4.
- Reset then LOAD r0 ← imm 0101; ADD r0 + imm 0001 twice → res_data 0101, 0110, 0111; rd_addr=0 gives rd_data 0111.
- LOAD r1 ← 1111; ADD r1 + imm 0001 → res_data 0000, carry_out 1, zero_out 1.
- LOAD r2 ← 0011, r3 ← 0101; SUB r2 − r3 (use_imm=0) → 1110, carry 1, zero 0. Then AND r3 with imm 1000 → 0000, carry 0, zero 1.
- With macro: MUL r2(0011)·imm 0101 → cmd_ready low 4 cycles, res_data 1111, carry 0. MUL of 0110·0100 → res_data 1000, carry 1.
- With macro: assert rst_n low 2 cycles into a MUL → registers 0, no res_valid, cmd_ready 1 after release.
- Without macro: op 111 on r0 = 0111 → res_valid pulse, res_data 0111, flags unchanged, cmd_ready stays 1.
